vu_level_ctrl: RTL and testbench

Level and peak-hold controller sitting between the UART receiver and the VGA bar renderer of the VU meter. Consumes signed 8-bit audio samples from the UART, tracks the maximum magnitude per video frame, and on each frame boundary commits a 4-bit bar level with decay and a 4-bit peak-hold marker. The VGA side reads `level` and `peak` as stable registers that change only once per frame, so bars never tear mid-scan.

---
 rtl/vu_level_ctrl.sv | 118 +++++++++++
 tb/tb_vu_level_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vu_level_ctrl.sv
// rtl/vu_level_ctrl.sv - per-frame VU bar level with decay and peak-hold marker
// Outputs only move in the single upd_strobe cycle so the renderer never sees a torn bar.
module vu_level_ctrl #(
   parameter int HOLD_FRAMES  = 30,
   parameter int DECAY_FRAMES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   input  logic       frame_start,
   output logic [3:0] level,
   output logic [3:0] peak,
   output logic       upd_strobe
);

   localparam int HW = (HOLD_FRAMES  > 1) ? $clog2(HOLD_FRAMES)  : 1;
   localparam int DW = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;
   localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_FRAMES - 1);
   localparam logic [DW-1:0] DECAY_MAX = DW'(DECAY_FRAMES - 1);

   typedef enum logic {ACC, UPD} state_t;

   state_t        state, state_n;
   logic [6:0]    win_max, win_max_n;
   logic [3:0]    cand, cand_n;
   logic [3:0]    level_n, peak_n, peak_dec;
   logic [HW-1:0] hold_cnt, hold_n;
   logic [DW-1:0] decay_cnt, decay_n;
   logic          strobe_n;
   logic [7:0]    neg;
   logic [6:0]    mag, sample_max;

   assign neg = 8'd0 - data_in;

   // 0x80 has no positive 8-bit counterpart, so clamp it to full scale
   always_comb begin
      mag = data_in[6:0];
      if (data_in == 8'h80)
         mag = 7'h7f;
      else if (data_in[7])
         mag = neg[6:0];
   end

   assign sample_max = (data_valid && (mag > win_max)) ? mag : win_max;

   always_comb begin
      state_n   = state;
      win_max_n = sample_max;
      cand_n    = cand;
      level_n   = level;
      peak_n    = peak;
      hold_n    = hold_cnt;
      decay_n   = decay_cnt;
      strobe_n  = 1'b0;
      peak_dec  = (peak == 4'd0) ? 4'd0 : peak - 4'd1;

      case (state)
         ACC: begin
            if (frame_start) begin
               cand_n    = win_max[6:3];
               win_max_n = data_valid ? mag : 7'd0;
               state_n   = UPD;
            end
         end
         UPD: begin
            if (cand >= level) begin
               level_n = cand;
               decay_n = '0;
            end else if (level != 4'd0) begin
               if (decay_cnt == DECAY_MAX) begin
                  level_n = level - 4'd1;
                  decay_n = '0;
               end else begin
                  decay_n = decay_cnt + 1'b1;
               end
            end

            // peak falls toward the new level, never below it
            if (cand >= peak) begin
               peak_n = cand;
               hold_n = '0;
            end else if (hold_cnt < HOLD_MAX) begin
               hold_n = hold_cnt + 1'b1;
            end else begin
               peak_n = (peak_dec > level_n) ? peak_dec : level_n;
            end

            strobe_n = 1'b1;
            state_n  = ACC;
         end
         default: state_n = ACC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ACC;
         win_max    <= 7'd0;
         cand       <= 4'd0;
         level      <= 4'd0;
         peak       <= 4'd0;
         hold_cnt   <= '0;
         decay_cnt  <= '0;
         upd_strobe <= 1'b0;
      end else begin
         state      <= state_n;
         win_max    <= win_max_n;
         cand       <= cand_n;
         level      <= level_n;
         peak       <= peak_n;
         hold_cnt   <= hold_n;
         decay_cnt  <= decay_n;
         upd_strobe <= strobe_n;
      end
   end

endmodule

// File: tb/tb_vu_level_ctrl.sv
// tb/tb_vu_level_ctrl.sv - directed self-checking bench for vu_level_ctrl
module tb_vu_level_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] data_in = 8'd0;
   logic       data_valid = 1'b0;
   logic       frame_start = 1'b0;
   logic [3:0] level, peak;
   logic       upd_strobe;

   int tests = 0;
   int fails = 0;

   vu_level_ctrl #(.HOLD_FRAMES(30), .DECAY_FRAMES(2)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
      .frame_start(frame_start), .level(level), .peak(peak), .upd_strobe(upd_strobe)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      data_valid = 1'b0;
      frame_start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic send(input logic [7:0] v);
      data_in = v;
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
   endtask

   // frame_start sampled at edge N; returns strobe at N+1..N+3 and level/peak around it
   task automatic do_frame(output logic s1, output logic s2, output logic s3,
                           output logic [3:0] lv_mid, output logic [3:0] lv,
                           output logic [3:0] pk);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      s1 = upd_strobe;
      lv_mid = level;
      tick();
      s2 = upd_strobe;
      lv = level;
      pk = peak;
      tick();
      s3 = upd_strobe;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         data_in = 8'($urandom);
         data_valid = 1'($urandom);
         frame_start = 1'($urandom);
         tick();
         tests++;
         if ({level, peak, upd_strobe} !== 9'd0) begin
            fails++;
            $display("FAIL reset_hold cycle %0d: level=%0d peak=%0d strobe=%0b, want 0 0 0",
                     i, level, peak, upd_strobe);
         end
      end
      rst = 1'b1;
      data_valid = 1'b0;
      frame_start = 1'b0;
      tick();
      tests++;
      if ({level, peak, upd_strobe} !== 9'd0) begin
         fails++;
         $display("FAIL reset_release: level=%0d peak=%0d strobe=%0b, want 0 0 0",
                  level, peak, upd_strobe);
      end
   endtask

   task automatic test_attack();
      logic s1, s2, s3;
      logic [3:0] lm, lv, pk;
      do_reset();
      send(8'h10);
      send(8'h50);
      send(8'h20);
      do_frame(s1, s2, s3, lm, lv, pk);
      tests++;
      if ({s1, s2, s3} !== 3'b010) begin
         fails++;
         $display("FAIL attack_strobe_timing: strobes N+1..N+3=%b, want 010", {s1, s2, s3});
      end
      tests++;
      if (lm !== 4'd0) begin
         fails++;
         $display("FAIL attack_level_early: level in N+1=%0d, want 0", lm);
      end
      tests++;
      if (lv !== 4'd10 || pk !== 4'd10) begin
         fails++;
         $display("FAIL attack_value: level=%0d peak=%0d, want 10 10", lv, pk);
      end
   endtask

   task automatic test_negative();
      logic s1, s2, s3;
      logic [3:0] lm, lv, pk;
      do_reset();
      send(8'h80);
      do_frame(s1, s2, s3, lm, lv, pk);
      tests++;
      if (lv !== 4'd15 || pk !== 4'd15) begin
         fails++;
         $display("FAIL neg_saturate: level=%0d peak=%0d, want 15 15", lv, pk);
      end
      do_reset();
      send(8'hF0);
      do_frame(s1, s2, s3, lm, lv, pk);
      tests++;
      if (lv !== 4'd2 || pk !== 4'd2) begin
         fails++;
         $display("FAIL neg_f0: level=%0d peak=%0d, want 2 2", lv, pk);
      end
   endtask

   task automatic test_decay_hold();
      logic s1, s2, s3;
      logic [3:0] lm, lv, pk, prev_lv, exp_lv, exp_pk;
      do_reset();
      send(8'h50);
      do_frame(s1, s2, s3, lm, lv, pk);
      prev_lv = 4'd10;
      for (int k = 1; k <= 32; k++) begin
         // level drops one step every second empty frame; peak holds 29 frames then falls
         exp_lv = (k >= 20) ? 4'd0 : 4'(10 - k / 2);
         exp_pk = (k <= 29) ? 4'd10 : 4'(10 - (k - 29));
         do_frame(s1, s2, s3, lm, lv, pk);
         tests++;
         if (lv !== exp_lv || pk !== exp_pk || s2 !== 1'b1) begin
            fails++;
            $display("FAIL decay_frame_%0d: level=%0d peak=%0d strobe=%0b, want %0d %0d 1",
                     k, lv, pk, s2, exp_lv, exp_pk);
         end
         tests++;
         if (lm !== prev_lv) begin
            fails++;
            $display("FAIL decay_stable_%0d: level before strobe=%0d, want %0d", k, lm, prev_lv);
         end
         prev_lv = exp_lv;
      end
   endtask

   task automatic test_simultaneous();
      logic s1, s2, s3;
      logic [3:0] lm, lv, pk;
      do_reset();
      data_in = 8'h7F;
      data_valid = 1'b1;
      frame_start = 1'b1;
      tick();
      data_valid = 1'b0;
      frame_start = 1'b0;
      tick();
      tests++;
      if (upd_strobe !== 1'b1 || level !== 4'd0 || peak !== 4'd0) begin
         fails++;
         $display("FAIL simul_first: strobe=%0b level=%0d peak=%0d, want 1 0 0",
                  upd_strobe, level, peak);
      end
      tick();
      do_frame(s1, s2, s3, lm, lv, pk);
      tests++;
      if (lv !== 4'd15 || pk !== 4'd15) begin
         fails++;
         $display("FAIL simul_next: level=%0d peak=%0d, want 15 15", lv, pk);
      end
   endtask

   task automatic test_reset_mid();
      logic s1, s2, s3;
      logic [3:0] lm, lv, pk;
      do_reset();
      send(8'h7F);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tests++;
      if (upd_strobe !== 1'b0 || level !== 4'd0 || peak !== 4'd0) begin
         fails++;
         $display("FAIL reset_mid: strobe=%0b level=%0d peak=%0d, want 0 0 0",
                  upd_strobe, level, peak);
      end
      tick();
      tests++;
      if (upd_strobe !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid_late: strobe=%0b, want 0", upd_strobe);
      end
      do_frame(s1, s2, s3, lm, lv, pk);
      tests++;
      if (lv !== 4'd0 || pk !== 4'd0 || s2 !== 1'b1) begin
         fails++;
         $display("FAIL reset_mid_next: level=%0d peak=%0d strobe=%0b, want 0 0 1", lv, pk, s2);
      end
   endtask

   task automatic test_back_to_back();
      logic s1, s2, s3;
      logic [3:0] lm, lv, pk;
      do_reset();
      send(8'h20);
      frame_start = 1'b1;
      tick();
      // still asserted during UPD: must be ignored; the sample here joins the new window
      data_in = 8'h50;
      data_valid = 1'b1;
      tick();
      frame_start = 1'b0;
      data_valid = 1'b0;
      tests++;
      if (upd_strobe !== 1'b1 || level !== 4'd4 || peak !== 4'd4) begin
         fails++;
         $display("FAIL b2b_first: strobe=%0b level=%0d peak=%0d, want 1 4 4",
                  upd_strobe, level, peak);
      end
      tick();
      tests++;
      if (upd_strobe !== 1'b0) begin
         fails++;
         $display("FAIL b2b_ignored: strobe=%0b, want 0", upd_strobe);
      end
      do_frame(s1, s2, s3, lm, lv, pk);
      tests++;
      if (lv !== 4'd10 || pk !== 4'd10) begin
         fails++;
         $display("FAIL b2b_upd_sample: level=%0d peak=%0d, want 10 10", lv, pk);
      end
   endtask

   initial begin
      test_reset();
      test_attack();
      test_negative();
      test_decay_hold();
      test_simultaneous();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
